// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel line-delay buffers and 3x3 window: primes two
// lines, then emits window-center coordinates tagged with sol/eol/eof markers.
module sobel_window_ctrl #(
   parameter int MAX_WIDTH_P  = 640,
   parameter int MAX_HEIGHT_P = 480,
   parameter int COL_W_P      = $clog2(MAX_WIDTH_P),
   parameter int ROW_W_P      = $clog2(MAX_HEIGHT_P)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [COL_W_P:0]   cfg_width_i,
   input  logic [ROW_W_P:0]   cfg_height_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               adv_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [COL_W_P-1:0] col_o,
   output logic [ROW_W_P-1:0] row_o,
   output logic               sol_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               busy_o,
   output logic               cfg_err_o,
   output logic               frame_done_o
);

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

   localparam logic [COL_W_P:0]   MIN_W_L = (COL_W_P+1)'(3);
   localparam logic [COL_W_P:0]   MAX_W_L = (COL_W_P+1)'(MAX_WIDTH_P);
   localparam logic [ROW_W_P:0]   MIN_H_L = (ROW_W_P+1)'(3);
   localparam logic [ROW_W_P:0]   MAX_H_L = (ROW_W_P+1)'(MAX_HEIGHT_P);
   localparam logic [COL_W_P:0]   ONE_W_L = (COL_W_P+1)'(1);
   localparam logic [ROW_W_P:0]   ONE_H_L = (ROW_W_P+1)'(1);
   localparam logic [COL_W_P-1:0] COL_ONE_L = COL_W_P'(1);
   localparam logic [COL_W_P-1:0] COL_TWO_L = COL_W_P'(2);
   localparam logic [ROW_W_P-1:0] ROW_ONE_L = ROW_W_P'(1);

   state_t             state_q;
   state_t             state_d;

   logic [COL_W_P:0]   w_q;
   logic [ROW_W_P:0]   h_q;
   logic [COL_W_P:0]   w_last;
   logic [ROW_W_P:0]   h_last;
   logic [COL_W_P-1:0] col_q;
   logic [ROW_W_P-1:0] row_q;

   logic               valid_q;
   logic [COL_W_P-1:0] col_out_q;
   logic [ROW_W_P-1:0] row_out_q;
   logic               sol_q;
   logic               eol_q;
   logic               eof_q;
   logic               cfg_err_q;

   logic               ready;
   logic               adv;
   logic               cfg_ok;
   logic               start_ok;
   logic               start_bad;
   logic               col_end;
   logic               row_end;
   logic               last_pix;
   logic               fill_done;
   logic               out_hs;
   logic               load_out;
   logic               frame_done;

   // Geometry checks and end-of-line/frame detection against the latched size.
   always_comb begin
      cfg_ok    = (cfg_width_i  >= MIN_W_L) && (cfg_width_i  <= MAX_W_L) &&
                  (cfg_height_i >= MIN_H_L) && (cfg_height_i <= MAX_H_L);
      start_ok  = (state_q == IDLE) && start_i && cfg_ok;
      start_bad = (state_q == IDLE) && start_i && !cfg_ok;
      w_last    = w_q - ONE_W_L;
      h_last    = h_q - ONE_H_L;
      col_end   = ({1'b0, col_q} == w_last);
      row_end   = ({1'b0, row_q} == h_last);
      last_pix  = col_end && row_end;
   end

   // Upstream ready: RUN can accept whenever the single output slot is free or draining.
   always_comb begin
      ready = 1'b0;
      case (state_q)
         IDLE:    ready = 1'b0;
         FILL:    ready = 1'b1;
         RUN:     ready = !valid_q || ready_i;
         DRAIN:   ready = 1'b0;
         default: ready = 1'b0;
      endcase
   end

   always_comb begin
      adv        = valid_i && ready;
      out_hs     = valid_q && ready_i;
      fill_done  = adv && col_end && (row_q == ROW_ONE_L);
      load_out   = adv && (state_q == RUN) && (col_q >= COL_TWO_L);
      frame_done = (state_q == DRAIN) && out_hs && eof_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok)          state_d = FILL;
         FILL:    if (fill_done)         state_d = RUN;
         RUN:     if (adv && last_pix)   state_d = DRAIN;
         DRAIN:   if (frame_done)        state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // Input raster counters; they only move on an accepted pixel.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_q   <= '0;
         h_q   <= '0;
         col_q <= '0;
         row_q <= '0;
      end else if (start_ok) begin
         w_q   <= cfg_width_i;
         h_q   <= cfg_height_i;
         col_q <= '0;
         row_q <= '0;
      end else if (adv) begin
         if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + ROW_ONE_L;
         end else begin
            col_q <= col_q + COL_ONE_L;
         end
      end
   end

   // Output stage: the window centred one row and one column behind the
   // accepted pixel is complete once that pixel has shifted in.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q   <= 1'b0;
         col_out_q <= '0;
         row_out_q <= '0;
         sol_q     <= 1'b0;
         eol_q     <= 1'b0;
         eof_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= start_bad;
         if (load_out) begin
            valid_q   <= 1'b1;
            col_out_q <= col_q - COL_ONE_L;
            row_out_q <= row_q - ROW_ONE_L;
            sol_q     <= (col_q == COL_TWO_L);
            eol_q     <= col_end;
            eof_q     <= last_pix;
         end else if (out_hs) begin
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
         end
      end
   end

   assign ready_o      = ready;
   assign adv_o        = adv;
   assign valid_o      = valid_q;
   assign col_o        = col_out_q;
   assign row_o        = row_out_q;
   assign sol_o        = sol_q;
   assign eol_o        = eol_q;
   assign eof_o        = eof_q;
   assign busy_o       = (state_q != IDLE);
   assign cfg_err_o    = cfg_err_q;
   assign frame_done_o = frame_done;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: frame sequencing, back-pressure,
// config rejection, mid-frame reset and a full-width randomised-handshake frame.
module tb_sobel_window_ctrl;

   localparam int MAX_W = 640;
   localparam int MAX_H = 480;
   localparam int COL_W = 10;
   localparam int ROW_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [COL_W:0]   cfg_width;
   logic [ROW_W:0]   cfg_height;
   logic             up_valid;
   logic             up_ready;
   logic             adv;
   logic             dn_valid;
   logic             dn_ready;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             sol;
   logic             eol;
   logic             eof;
   logic             busy;
   logic             cfg_err;
   logic             frame_done;

   int tests_run = 0;
   int failures  = 0;

   // Observations gathered by the frame driver.
   logic [COL_W-1:0] got_col_q[$];
   logic [ROW_W-1:0] got_row_q[$];
   logic [2:0]       got_mark_q[$];
   int adv_cnt;
   int done_cnt;
   int first_valid_adv;
   int adv_bad;
   int timed_out;
   logic busy_at_done;
   logic busy_after_done;
   logic stall_ready_seen;
   logic stall_move_seen;

   always #5 clk = ~clk;

   sobel_window_ctrl #(
      .MAX_WIDTH_P (MAX_W),
      .MAX_HEIGHT_P(MAX_H)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .cfg_width_i (cfg_width),
      .cfg_height_i(cfg_height),
      .valid_i     (up_valid),
      .ready_o     (up_ready),
      .adv_o       (adv),
      .valid_o     (dn_valid),
      .ready_i     (dn_ready),
      .col_o       (col),
      .row_o       (row),
      .sol_o       (sol),
      .eol_o       (eol),
      .eof_o       (eof),
      .busy_o      (busy),
      .cfg_err_o   (cfg_err),
      .frame_done_o(frame_done)
   );

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
      $fatal(1, "watchdog");
   end

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                            input int stall, input int start_at, input int budget);
      int cyc;
      int stall_left;
      logic seen;
      logic done;
      logic in_stall;
      logic [COL_W-1:0] held_col;
      logic [ROW_W-1:0] held_row;
      got_col_q.delete();
      got_row_q.delete();
      got_mark_q.delete();
      adv_cnt = 0; done_cnt = 0; first_valid_adv = -1; adv_bad = 0;
      busy_at_done = 1'b0; busy_after_done = 1'b1;
      stall_ready_seen = 1'b0; stall_move_seen = 1'b0;
      seen = 1'b0; done = 1'b0; stall_left = 0; held_col = '0; held_row = '0;
      @(negedge clk);
      start = 1'b1; cfg_width = (COL_W+1)'(w); cfg_height = (ROW_W+1)'(h);
      up_valid = 1'b0; dn_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < budget) begin
         if (dn_valid && !seen) begin
            seen = 1'b1; first_valid_adv = adv_cnt;
            held_col = col; held_row = row; stall_left = stall;
         end
         up_valid = ($urandom_range(0, 99) < vpct);
         dn_ready = ($urandom_range(0, 99) < rpct);
         in_stall = 1'b0;
         if (stall_left > 0) begin
            dn_ready = 1'b0; stall_left--; in_stall = 1'b1;
         end
         start = (cyc == start_at);
         if (start) begin
            cfg_width = (COL_W+1)'(3); cfg_height = (ROW_W+1)'(3);
         end
         #1;
         if (adv !== (up_valid & up_ready)) adv_bad++;
         if (in_stall) begin
            if (up_ready) stall_ready_seen = 1'b1;
            if (!dn_valid || col != held_col || row != held_row) stall_move_seen = 1'b1;
         end
         if (adv) adv_cnt++;
         if (dn_valid && dn_ready) begin
            got_col_q.push_back(col);
            got_row_q.push_back(row);
            got_mark_q.push_back({sol, eol, eof});
         end
         if (frame_done) begin
            done_cnt++; busy_at_done = busy; done = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
      #1;
      busy_after_done = busy;
      if (frame_done) done_cnt++;
      timed_out = done ? 0 : 1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
      up_valid = 1'b1; dn_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if ({up_ready, adv, dn_valid, busy, cfg_err, frame_done} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl got %b exp 000000", {up_ready, adv, dn_valid, busy, cfg_err, frame_done});
      end
      tests_run++;
      if ({col, row, sol, eol, eof} !== '0) begin
         failures++;
         $display("FAIL reset_data got col=%0d row=%0d marks=%b exp 0", col, row, {sol, eol, eof});
      end
      @(negedge clk);
      rst = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
   endtask

   task automatic test_basic_4x4();
      int r, c;
      logic [2:0] em;
      run_frame(4, 4, 100, 100, 0, -1, 200);
      tests_run++;
      if (timed_out !== 0) begin failures++; $display("FAIL b4_timeout got %0d exp 0", timed_out); end
      tests_run++;
      if (first_valid_adv !== 11) begin failures++; $display("FAIL b4_latency got %0d exp 11", first_valid_adv); end
      tests_run++;
      if (got_col_q.size() !== 4) begin failures++; $display("FAIL b4_count got %0d exp 4", got_col_q.size()); end
      for (int k = 0; k < got_col_q.size() && k < 4; k++) begin
         r = 1 + k / 2; c = 1 + k % 2;
         em = {c == 1, c == 2, (r == 2) && (c == 2)};
         tests_run++;
         if (int'(got_row_q[k]) !== r || int'(got_col_q[k]) !== c) begin
            failures++;
            $display("FAIL b4_coord[%0d] got (%0d,%0d) exp (%0d,%0d)", k, got_row_q[k], got_col_q[k], r, c);
         end
         tests_run++;
         if (got_mark_q[k] !== em) begin
            failures++; $display("FAIL b4_marks[%0d] got %b exp %b", k, got_mark_q[k], em);
         end
      end
      tests_run++;
      if (adv_cnt !== 16) begin failures++; $display("FAIL b4_adv got %0d exp 16", adv_cnt); end
      tests_run++;
      if (done_cnt !== 1) begin failures++; $display("FAIL b4_done got %0d exp 1", done_cnt); end
      tests_run++;
      if ({busy_at_done, busy_after_done} !== 2'b10) begin
         failures++; $display("FAIL b4_busy got %b exp 10", {busy_at_done, busy_after_done});
      end
      tests_run++;
      if (adv_bad !== 0) begin failures++; $display("FAIL b4_adv_eq got %0d exp 0", adv_bad); end
   endtask

   task automatic test_back_pressure();
      int c;
      logic [2:0] em;
      run_frame(5, 3, 100, 100, 3, -1, 200);
      tests_run++;
      if (timed_out !== 0) begin failures++; $display("FAIL bp_timeout got %0d exp 0", timed_out); end
      tests_run++;
      if (first_valid_adv !== 13) begin failures++; $display("FAIL bp_latency got %0d exp 13", first_valid_adv); end
      tests_run++;
      if (stall_ready_seen !== 1'b0) begin failures++; $display("FAIL bp_ready got %b exp 0", stall_ready_seen); end
      tests_run++;
      if (stall_move_seen !== 1'b0) begin failures++; $display("FAIL bp_hold got %b exp 0", stall_move_seen); end
      tests_run++;
      if (got_col_q.size() !== 3) begin failures++; $display("FAIL bp_count got %0d exp 3", got_col_q.size()); end
      for (int k = 0; k < got_col_q.size() && k < 3; k++) begin
         c = 1 + k;
         em = {c == 1, c == 3, c == 3};
         tests_run++;
         if (int'(got_row_q[k]) !== 1 || int'(got_col_q[k]) !== c) begin
            failures++;
            $display("FAIL bp_coord[%0d] got (%0d,%0d) exp (1,%0d)", k, got_row_q[k], got_col_q[k], c);
         end
         tests_run++;
         if (got_mark_q[k] !== em) begin
            failures++; $display("FAIL bp_marks[%0d] got %b exp %b", k, got_mark_q[k], em);
         end
      end
      tests_run++;
      if (adv_cnt !== 15) begin failures++; $display("FAIL bp_adv got %0d exp 15", adv_cnt); end
      tests_run++;
      if (done_cnt !== 1) begin failures++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_cfg_err();
      int bad_w[3] = '{2, 4, MAX_W + 1};
      int bad_h[3] = '{4, MAX_H + 1, 4};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b1; up_valid = 1'b1;
         cfg_width = (COL_W+1)'(bad_w[i]); cfg_height = (ROW_W+1)'(bad_h[i]);
         @(negedge clk);
         start = 1'b0;
         #1;
         tests_run++;
         if ({cfg_err, busy, up_ready} !== 3'b100) begin
            failures++;
            $display("FAIL cfg_reject[%0d] got err/busy/ready=%b exp 100", i, {cfg_err, busy, up_ready});
         end
         @(negedge clk);
         #1;
         tests_run++;
         if ({cfg_err, busy, up_ready} !== 3'b000) begin
            failures++;
            $display("FAIL cfg_pulse[%0d] got err/busy/ready=%b exp 000", i, {cfg_err, busy, up_ready});
         end
      end
      up_valid = 1'b0;
   endtask

   task automatic test_min_frame();
      run_frame(3, 3, 100, 100, 0, -1, 100);
      tests_run++;
      if (got_col_q.size() !== 1) begin failures++; $display("FAIL min_count got %0d exp 1", got_col_q.size()); end
      if (got_col_q.size() > 0) begin
         tests_run++;
         if ({got_row_q[0], got_col_q[0], got_mark_q[0]} !== {9'd1, 10'd1, 3'b111}) begin
            failures++;
            $display("FAIL min_out got (%0d,%0d) marks %b exp (1,1) 111", got_row_q[0], got_col_q[0], got_mark_q[0]);
         end
      end
      tests_run++;
      if (adv_cnt !== 9 || done_cnt !== 1) begin
         failures++; $display("FAIL min_adv_done got %0d/%0d exp 9/1", adv_cnt, done_cnt);
      end
   endtask

   task automatic test_reset_mid_run();
      int r, c;
      logic [2:0] em;
      @(negedge clk);
      start = 1'b1; cfg_width = (COL_W+1)'(6); cfg_height = (ROW_W+1)'(6);
      @(negedge clk);
      start = 1'b0; up_valid = 1'b1; dn_ready = 1'b1;
      repeat (13) @(negedge clk);
      #1;
      tests_run++;
      if ({busy, up_ready} !== 2'b11) begin
         failures++; $display("FAIL mid_pre got busy/ready=%b exp 11", {busy, up_ready});
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if ({up_ready, adv, dn_valid, busy, cfg_err, frame_done, sol, eol, eof} !== 9'b0 || col !== '0 || row !== '0) begin
         failures++;
         $display("FAIL mid_reset got ctrl=%b col=%0d row=%0d exp all 0",
                  {up_ready, adv, dn_valid, busy, cfg_err, frame_done, sol, eol, eof}, col, row);
      end
      rst = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
      run_frame(6, 6, 100, 100, 0, -1, 300);
      tests_run++;
      if (got_col_q.size() !== 16) begin failures++; $display("FAIL mid_count got %0d exp 16", got_col_q.size()); end
      for (int k = 0; k < got_col_q.size() && k < 16; k++) begin
         r = 1 + k / 4; c = 1 + k % 4;
         em = {c == 1, c == 4, (r == 4) && (c == 4)};
         tests_run++;
         if (int'(got_row_q[k]) !== r || int'(got_col_q[k]) !== c || got_mark_q[k] !== em) begin
            failures++;
            $display("FAIL mid_out[%0d] got (%0d,%0d) %b exp (%0d,%0d) %b",
                     k, got_row_q[k], got_col_q[k], got_mark_q[k], r, c, em);
         end
      end
      tests_run++;
      if (done_cnt !== 1) begin failures++; $display("FAIL mid_done got %0d exp 1", done_cnt); end
   endtask

   task automatic test_random_max_width();
      int r, c;
      int n_exp;
      logic [2:0] em;
      n_exp = 3 * (MAX_W - 2);
      run_frame(MAX_W, 5, 50, 50, 0, 700, 40000);
      tests_run++;
      if (timed_out !== 0) begin failures++; $display("FAIL rnd_timeout got %0d exp 0", timed_out); end
      tests_run++;
      if (got_col_q.size() !== n_exp) begin
         failures++; $display("FAIL rnd_count got %0d exp %0d", got_col_q.size(), n_exp);
      end
      tests_run++;
      if (adv_cnt !== 5 * MAX_W) begin failures++; $display("FAIL rnd_adv got %0d exp %0d", adv_cnt, 5 * MAX_W); end
      tests_run++;
      if (done_cnt !== 1) begin failures++; $display("FAIL rnd_done got %0d exp 1", done_cnt); end
      tests_run++;
      if (adv_bad !== 0) begin failures++; $display("FAIL rnd_adv_eq got %0d exp 0", adv_bad); end
      for (int k = 0; k < got_col_q.size() && k < n_exp; k++) begin
         r = 1 + k / (MAX_W - 2); c = 1 + k % (MAX_W - 2);
         em = {c == 1, c == MAX_W - 2, (r == 3) && (c == MAX_W - 2)};
         tests_run++;
         if (int'(got_row_q[k]) !== r || int'(got_col_q[k]) !== c || got_mark_q[k] !== em) begin
            failures++;
            $display("FAIL rnd_out[%0d] got (%0d,%0d) %b exp (%0d,%0d) %b",
                     k, got_row_q[k], got_col_q[k], got_mark_q[k], r, c, em);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_4x4();
      test_back_pressure();
      test_cfg_err();
      test_min_frame();
      test_reset_mid_run();
      test_random_max_width();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
